// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution memory arbiter.
//   owner_t      - which requester currently owns the memory port
//   arb_state_t  - arbiter FSM states
//   CONV_ADDR_W  - memory word-address width
//   CONV_BLEN_W  - width of the burst-length-minus-one fields
//   beat_total() - number of beats in a burst given its blen field
package conv_pkg;

  localparam int unsigned CONV_ADDR_W = 28;
  localparam int unsigned CONV_BLEN_W = 6;

  typedef enum logic [1:0] {
    OWN_RD,
    OWN_WR,
    OWN_HST
  } owner_t;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    BURST,
    DRAIN,
    DONE
  } arb_state_t;

  // blen encodes length-1; one extra bit so 64 beats fits.
  function automatic logic [CONV_BLEN_W:0] beat_total(input logic [CONV_BLEN_W-1:0] blen);
    return {1'b0, blen} + {{CONV_BLEN_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/conv_rr_pick.sv
// conv_rr_pick: combinational two-way round-robin selector between the
// conv read and write requesters.
//   rd_req, wr_req - pending requests
//   last_own       - owner of the previous rd/wr burst
//   any_req        - at least one request is pending
//   winner         - selected owner (OWN_RD or OWN_WR)
// A lone requester always wins; on a tie the side that did not go last wins.
module conv_rr_pick
  import conv_pkg::*;
(
  input  logic   rd_req,
  input  logic   wr_req,
  input  owner_t last_own,
  output logic   any_req,
  output owner_t winner
);

  always_comb begin
    any_req = rd_req | wr_req;
    winner  = OWN_RD;
    if (wr_req && (!rd_req || last_own == OWN_RD)) begin
      winner = OWN_WR;
    end
  end

endmodule

// File: rtl/conv_mem_arb.sv
// conv_mem_arb: shares the single external memory port between the conv read
// block, the conv write block and, when CONV_MEM_ARB_HOST_EN is defined, the
// system-top loader (host). One burst owner at a time; the burst is driven
// beat-by-beat and read data is broadcast on rdata.
//   clk, rst_n                       - clock, async active-low reset
//   rd_req/addr/blen, rd_gnt/rvalid/done
//                                    - read-block burst port
//   wr_req/addr/blen/wdata, wr_gnt/ack/done
//                                    - write-block burst port
//   hst_* (CONV_MEM_ARB_HOST_EN only)- host burst port, direction by hst_we,
//                                      absolute priority
//   rdata                            - read data (mem_rdata passthrough)
//   mem_en/we/addr/wdata, mem_rdy    - memory beat request side
//   mem_rvalid, mem_rdata            - in-order read returns
//   arb_err                          - sticky: read return with none outstanding
module conv_mem_arb
  import conv_pkg::*;
#(
  parameter int unsigned word_len = 32,
  parameter int unsigned addr_w   = CONV_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_req,
  input  logic [addr_w-1:0]      rd_addr,
  input  logic [CONV_BLEN_W-1:0] rd_blen,
  output logic                   rd_gnt,
  output logic                   rd_rvalid,
  output logic                   rd_done,
  input  logic                   wr_req,
  input  logic [addr_w-1:0]      wr_addr,
  input  logic [CONV_BLEN_W-1:0] wr_blen,
  input  logic [word_len-1:0]    wr_wdata,
  output logic                   wr_gnt,
  output logic                   wr_ack,
  output logic                   wr_done,
`ifdef CONV_MEM_ARB_HOST_EN
  input  logic                   hst_req,
  input  logic [addr_w-1:0]      hst_addr,
  input  logic [CONV_BLEN_W-1:0] hst_blen,
  input  logic                   hst_we,
  input  logic [word_len-1:0]    hst_wdata,
  output logic                   hst_gnt,
  output logic                   hst_ack,
  output logic                   hst_rvalid,
  output logic                   hst_done,
`endif
  output logic [word_len-1:0]    rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [addr_w-1:0]      mem_addr,
  output logic [word_len-1:0]    mem_wdata,
  input  logic                   mem_rdy,
  input  logic                   mem_rvalid,
  input  logic [word_len-1:0]    mem_rdata,
  output logic                   arb_err
);

  localparam int unsigned CW = CONV_BLEN_W + 1;

  arb_state_t             state, state_nxt;
  owner_t                 owner_q, last_q, pick_own, sel_own;
  logic                   pick_any, sel_any, sel_we;
  logic [addr_w-1:0]      sel_addr;
  logic [CONV_BLEN_W-1:0] sel_blen, blen_q;
  logic [CW-1:0]          beats, issued_q, returned_q, issued_nxt, returned_nxt;
  logic                   beat_ok, rv_ok;

  conv_rr_pick u_pick (
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .last_own (last_q),
    .any_req  (pick_any),
    .winner   (pick_own)
  );

  // Host override sits outside the round-robin so it never moves the pointer.
  always_comb begin
    sel_any = pick_any;
    sel_own = pick_own;
`ifdef CONV_MEM_ARB_HOST_EN
    if (hst_req) begin
      sel_any = 1'b1;
      sel_own = OWN_HST;
    end
`endif
    sel_addr = rd_addr;
    sel_blen = rd_blen;
    sel_we   = 1'b0;
    if (sel_own == OWN_WR) begin
      sel_addr = wr_addr;
      sel_blen = wr_blen;
      sel_we   = 1'b1;
    end
`ifdef CONV_MEM_ARB_HOST_EN
    if (sel_own == OWN_HST) begin
      sel_addr = hst_addr;
      sel_blen = hst_blen;
      sel_we   = hst_we;
    end
`endif
  end

  assign rdata = mem_rdata;
  assign beats = beat_total(blen_q);

  // Returns are accepted only for a read burst still short of its beat total;
  // anything else is a stray return.
  always_comb begin
    beat_ok      = (state == BURST) && mem_rdy;
    rv_ok        = mem_rvalid && !mem_we && (state == BURST || state == DRAIN) &&
                   (returned_q != beats);
    issued_nxt   = issued_q + CW'(beat_ok);
    returned_nxt = returned_q + CW'(rv_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_q    <= OWN_RD;
      last_q     <= OWN_WR;
      blen_q     <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      arb_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mem_rvalid && !rv_ok) begin
        arb_err <= 1'b1;
      end
      if (state == IDLE && sel_any) begin
        owner_q  <= sel_own;
        blen_q   <= sel_blen;
        mem_addr <= sel_addr;
        mem_we   <= sel_we;
        if (sel_own != OWN_HST) begin
          last_q <= sel_own;
        end
      end
      if (state == GRANT) begin
        issued_q   <= '0;
        returned_q <= '0;
      end else begin
        issued_q   <= issued_nxt;
        returned_q <= returned_nxt;
      end
      if (beat_ok) begin
        mem_addr <= mem_addr + addr_w'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rd_gnt    = 1'b0;
    rd_rvalid = 1'b0;
    rd_done   = 1'b0;
    wr_gnt    = 1'b0;
    wr_ack    = 1'b0;
    wr_done   = 1'b0;
    mem_en    = 1'b0;
    mem_wdata = '0;
`ifdef CONV_MEM_ARB_HOST_EN
    hst_gnt    = 1'b0;
    hst_ack    = 1'b0;
    hst_rvalid = 1'b0;
    hst_done   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sel_any) state_nxt = GRANT;
      end
      GRANT: begin
        state_nxt = BURST;
        rd_gnt    = (owner_q == OWN_RD);
        wr_gnt    = (owner_q == OWN_WR);
`ifdef CONV_MEM_ARB_HOST_EN
        hst_gnt   = (owner_q == OWN_HST);
`endif
      end
      BURST: begin
        mem_en = 1'b1;
        if (owner_q == OWN_WR) begin
          wr_ack    = mem_rdy;
          mem_wdata = wr_wdata;
        end
`ifdef CONV_MEM_ARB_HOST_EN
        if (owner_q == OWN_HST && mem_we) begin
          hst_ack   = mem_rdy;
          mem_wdata = hst_wdata;
        end
`endif
        if (beat_ok && issued_nxt == beats) begin
          state_nxt = (mem_we || returned_nxt == beats) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (returned_nxt == beats) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        rd_done   = (owner_q == OWN_RD);
        wr_done   = (owner_q == OWN_WR);
`ifdef CONV_MEM_ARB_HOST_EN
        hst_done  = (owner_q == OWN_HST);
`endif
      end
      default: state_nxt = IDLE;
    endcase
    rd_rvalid  = rv_ok && (owner_q == OWN_RD);
`ifdef CONV_MEM_ARB_HOST_EN
    hst_rvalid = rv_ok && (owner_q == OWN_HST);
`endif
  end

endmodule

// File: tb/tb_conv_mem_arb.sv
// tb_conv_mem_arb: directed self-checking bench for conv_mem_arb.
// Build with CONV_MEM_ARB_HOST_EN defined to also exercise the host port.
module tb_conv_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [27:0] rd_addr = '0;
  logic [5:0]  rd_blen = '0;
  logic        rd_gnt, rd_rvalid, rd_done;
  logic        wr_req = 1'b0;
  logic [27:0] wr_addr = '0;
  logic [5:0]  wr_blen = '0;
  logic [31:0] wr_wdata = '0;
  logic        wr_gnt, wr_ack, wr_done;
`ifdef CONV_MEM_ARB_HOST_EN
  logic        hst_req = 1'b0;
  logic [27:0] hst_addr = '0;
  logic [5:0]  hst_blen = '0;
  logic        hst_we = 1'b0;
  logic [31:0] hst_wdata = '0;
  logic        hst_gnt, hst_ack, hst_rvalid, hst_done;
`endif
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [27:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdy = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        arb_err;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic        rdy_mode = 1'b0;
  logic        rdy_tog = 1'b1;

  typedef struct {
    int unsigned due;
    logic [27:0] addr;
  } rv_t;
  rv_t rvq[$];

  conv_mem_arb #(.word_len(32), .addr_w(28)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_blen    (rd_blen),
    .rd_gnt     (rd_gnt),
    .rd_rvalid  (rd_rvalid),
    .rd_done    (rd_done),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_blen    (wr_blen),
    .wr_wdata   (wr_wdata),
    .wr_gnt     (wr_gnt),
    .wr_ack     (wr_ack),
    .wr_done    (wr_done),
`ifdef CONV_MEM_ARB_HOST_EN
    .hst_req    (hst_req),
    .hst_addr   (hst_addr),
    .hst_blen   (hst_blen),
    .hst_we     (hst_we),
    .hst_wdata  (hst_wdata),
    .hst_gnt    (hst_gnt),
    .hst_ack    (hst_ack),
    .hst_rvalid (hst_rvalid),
    .hst_done   (hst_done),
`endif
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdy    (mem_rdy),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .arb_err    (arb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [27:0] a);
    return {4'hA, a};
  endfunction

  // Memory model: called just after a negedge; drives this cycle's inputs,
  // lets the DUT settle, then queues a return two cycles after each read beat.
  task automatic drive_cycle();
    rv_t e;
    cyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rvq.size() > 0 && rvq[0].due == cyc) begin
      e          = rvq.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = data_of(e.addr);
    end
    if (rdy_mode) begin
      mem_rdy = rdy_tog;
      rdy_tog = ~rdy_tog;
    end else begin
      mem_rdy = 1'b1;
    end
    #1;
    if (mem_en && mem_rdy && !mem_we) rvq.push_back('{due: cyc + 2, addr: mem_addr});
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
`ifdef CONV_MEM_ARB_HOST_EN
    hst_req = 1'b0;
`endif
    mem_rvalid = 1'b0;
    rvq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    obs = {rd_gnt, wr_gnt, rd_done, wr_done, wr_ack, rd_rvalid, mem_en, mem_we, arb_err};
    total++;
    if (obs !== 9'b0) begin bad++; $display("FAIL reset_ctl got=%b want=%b", obs, 9'b0); end
    total++;
    if (mem_addr !== 28'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
    total++;
    if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    drive_cycle();
    obs = {rd_gnt, wr_gnt, rd_done, wr_done, wr_ack, rd_rvalid, mem_en, mem_we, arb_err};
    total++;
    if (obs !== 9'b0) begin bad++; $display("FAIL post_reset_idle got=%b want=%b", obs, 9'b0); end
  endtask

  task automatic test_rd_only();
    int gnt_c = -1, first_en = -1, done_c = -1, last_rv = -1;
    int n_iss = 0, n_rv = 0, n_done = 0;
    rdy_mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin rd_addr = 28'h100; rd_blen = 6'd3; rd_req = 1'b1; end
      drive_cycle();
      if (rd_gnt) begin gnt_c = i; rd_req = 1'b0; end
      if (mem_en && first_en < 0) first_en = i;
      if (mem_en && mem_rdy) begin
        total++;
        if (mem_addr !== 28'h100 + 28'(n_iss) || mem_we !== 1'b0) begin
          bad++;
          $display("FAIL rd_issue%0d got addr=%h we=%b want addr=%h we=0", n_iss, mem_addr, mem_we, 28'h100 + 28'(n_iss));
        end
        n_iss++;
      end
      if (rd_rvalid) begin
        total++;
        if (rdata !== data_of(28'h100 + 28'(n_rv))) begin
          bad++;
          $display("FAIL rd_data%0d got=%h want=%h", n_rv, rdata, data_of(28'h100 + 28'(n_rv)));
        end
        n_rv++;
        last_rv = i;
      end
      if (rd_done) begin n_done++; done_c = i; end
    end
    total++;
    if (gnt_c !== 1) begin bad++; $display("FAIL rd_gnt_cycle got=%0d want=1", gnt_c); end
    total++;
    if (first_en !== 2) begin bad++; $display("FAIL rd_first_en got=%0d want=2", first_en); end
    total++;
    if (n_iss !== 4) begin bad++; $display("FAIL rd_issue_count got=%0d want=4", n_iss); end
    total++;
    if (n_rv !== 4) begin bad++; $display("FAIL rd_rvalid_count got=%0d want=4", n_rv); end
    total++;
    if (last_rv !== 7) begin bad++; $display("FAIL rd_last_return got=%0d want=7", last_rv); end
    total++;
    if (n_done !== 1 || done_c !== 8) begin
      bad++;
      $display("FAIL rd_done got count=%0d cycle=%0d want count=1 cycle=8", n_done, done_c);
    end
  endtask

  task automatic test_wr_only();
    logic [31:0] beat[2];
    int n_ack = 0;
    beat[0] = 32'hCAFE_0000;
    beat[1] = 32'hCAFE_0001;
    rdy_mode = 1'b1;
    rdy_tog  = 1'b1;
    wr_wdata = beat[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin wr_addr = 28'h200; wr_blen = 6'd1; wr_req = 1'b1; end
      drive_cycle();
      if (wr_gnt) wr_req = 1'b0;
      total++;
      if (wr_ack !== (i == 2 || i == 4)) begin
        bad++;
        $display("FAIL wr_ack_c%0d got=%b want=%b", i, wr_ack, (i == 2 || i == 4));
      end
      total++;
      if (wr_done !== (i == 5)) begin
        bad++;
        $display("FAIL wr_done_c%0d got=%b want=%b", i, wr_done, (i == 5));
      end
      if (wr_ack && n_ack < 2) begin
        total++;
        if (mem_wdata !== beat[n_ack] || mem_addr !== 28'h200 + 28'(n_ack) || mem_we !== 1'b1) begin
          bad++;
          $display("FAIL wr_beat%0d got data=%h addr=%h we=%b want data=%h addr=%h we=1",
                   n_ack, mem_wdata, mem_addr, mem_we, beat[n_ack], 28'h200 + 28'(n_ack));
        end
        n_ack++;
        if (n_ack < 2) wr_wdata = beat[n_ack];
      end
    end
    rdy_mode = 1'b0;
  endtask

  task automatic test_wrap();
    logic [27:0] exp_a[4];
    int n_ack = 0, n_done = 0;
    exp_a[0] = 28'hFFF_FFFE;
    exp_a[1] = 28'hFFF_FFFF;
    exp_a[2] = 28'h000_0000;
    exp_a[3] = 28'h000_0001;
    rdy_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin wr_addr = 28'hFFF_FFFE; wr_blen = 6'd3; wr_wdata = 32'h5A5A_0000; wr_req = 1'b1; end
      drive_cycle();
      if (wr_gnt) wr_req = 1'b0;
      if (wr_ack && n_ack < 4) begin
        total++;
        if (mem_addr !== exp_a[n_ack]) begin
          bad++;
          $display("FAIL wrap_addr%0d got=%h want=%h", n_ack, mem_addr, exp_a[n_ack]);
        end
        n_ack++;
      end
      if (wr_done) n_done++;
    end
    total++;
    if (n_ack !== 4 || n_done !== 1) begin
      bad++;
      $display("FAIL wrap_counts got ack=%0d done=%0d want ack=4 done=1", n_ack, n_done);
    end
  endtask

  task automatic test_round_robin();
    rdy_mode = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rd_addr = 28'h300; rd_blen = 6'd0; wr_addr = 28'h400; wr_blen = 6'd0;
        rd_req = 1'b1; wr_req = 1'b1;
      end
      drive_cycle();
      total++;
      if (rd_gnt !== (i == 1 || i == 11) || wr_gnt !== (i == 7)) begin
        bad++;
        $display("FAIL rr_gnt_c%0d got rd=%b wr=%b want rd=%b wr=%b", i, rd_gnt, wr_gnt, (i == 1 || i == 11), (i == 7));
      end
      total++;
      if (rd_done !== (i == 5 || i == 15) || wr_done !== (i == 9)) begin
        bad++;
        $display("FAIL rr_done_c%0d got rd=%b wr=%b want rd=%b wr=%b", i, rd_done, wr_done, (i == 5 || i == 15), (i == 9));
      end
      if (i == 11) begin rd_req = 1'b0; wr_req = 1'b0; end
    end
  endtask

  task automatic test_err_reset();
    logic [8:0] obs;
    @(negedge clk);
    #1;
    total++;
    if (arb_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", arb_err); end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    #1;
    total++;
    if (rd_rvalid !== 1'b0) begin bad++; $display("FAIL stray_rvalid got=%b want=0", rd_rvalid); end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    total++;
    if (arb_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", arb_err); end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (arb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", arb_err); end

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin rd_addr = 28'h500; rd_blen = 6'd7; rd_req = 1'b1; end
      drive_cycle();
      if (rd_gnt) rd_req = 1'b0;
    end
    total++;
    if (mem_en !== 1'b1) begin bad++; $display("FAIL midburst_en got=%b want=1", mem_en); end
    #1;
    rst_n = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    obs = {rd_gnt, wr_gnt, rd_done, wr_done, wr_ack, rd_rvalid, mem_en, mem_we, arb_err};
    total++;
    if (obs !== 9'b0 || mem_addr !== 28'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL midburst_reset got ctl=%b addr=%h wdata=%h want all 0", obs, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rvq.delete();
    mem_rvalid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rd_addr = 28'h600; rd_blen = 6'd0; wr_addr = 28'h700; wr_blen = 6'd0;
        rd_req = 1'b1; wr_req = 1'b1;
      end
      drive_cycle();
      if (i == 1) begin rd_req = 1'b0; wr_req = 1'b0; end
      total++;
      if (rd_gnt !== (i == 1) || wr_gnt !== 1'b0 || rd_done !== (i == 5)) begin
        bad++;
        $display("FAIL after_reset_c%0d got gnt=%b/%b done=%b want gnt=%b/0 done=%b",
                 i, rd_gnt, wr_gnt, rd_done, (i == 1), (i == 5));
      end
    end
  endtask

`ifdef CONV_MEM_ARB_HOST_EN
  task automatic test_host();
    apply_reset();
    rdy_mode = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) begin
        hst_addr = 28'h800; hst_blen = 6'd0; hst_we = 1'b1; hst_wdata = 32'h1234_5678;
        rd_addr = 28'h900; rd_blen = 6'd0; wr_addr = 28'hA00; wr_blen = 6'd0;
        hst_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
      end
      drive_cycle();
      total++;
      if (hst_gnt !== (i == 1) || rd_gnt !== (i == 5) || wr_gnt !== (i == 11)) begin
        bad++;
        $display("FAIL host_gnt_c%0d got h=%b r=%b w=%b want h=%b r=%b w=%b",
                 i, hst_gnt, rd_gnt, wr_gnt, (i == 1), (i == 5), (i == 11));
      end
      total++;
      if (hst_ack !== (i == 2) || (hst_ack && mem_wdata !== 32'h1234_5678)) begin
        bad++;
        $display("FAIL host_ack_c%0d got ack=%b data=%h want ack=%b data=12345678", i, hst_ack, mem_wdata, (i == 2));
      end
      if (hst_gnt) hst_req = 1'b0;
      if (rd_gnt) rd_req = 1'b0;
      if (wr_gnt) wr_req = 1'b0;
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rd_only();
    test_wr_only();
    test_wrap();
    test_round_robin();
    test_err_reset();
`ifdef CONV_MEM_ARB_HOST_EN
    test_host();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
